// File: rtl/register_bank_sweep.sv
// DEPTH x DATA_W register bank: one write port, two registered read ports, multi-cycle clear sweep.
// Define REGFILE_BYPASS_EN for same-edge write-to-read forwarding.
module register_bank_sweep #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Write_Enable,
    input  logic [ADDR_W-1:0] Destination,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic [ADDR_W-1:0] Source1,
    input  logic [ADDR_W-1:0] Source2,
    input  logic              Clear_Start,
    output logic              Busy,
    output logic [DATA_W-1:0] Output_1,
    output logic [DATA_W-1:0] Output_2
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {StIdle, StSweep} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] out1_q, out2_q;
    logic [DATA_W-1:0] rd1, rd2;
    logic              sweeping;
    logic              wr_accept;

    assign sweeping  = (state_q == StSweep);
    // Writes are dropped during a sweep and, with ZERO_REG, when aimed at entry 0.
    assign wr_accept = Write_Enable && !sweeping &&
                       !((ZERO_REG != 0) && (Destination == '0));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (Clear_Start) begin
                    state_d = StSweep;
                    idx_d   = '0;
                end
            end
            StSweep: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_accept) begin
            regs_d[Destination] = Write_Data;
        end
        if (sweeping) begin
            regs_d[idx_q] = '0;
        end
    end

    always_comb begin
        rd1 = regs_q[Source1];
        rd2 = regs_q[Source2];
`ifdef REGFILE_BYPASS_EN
        if (wr_accept && (Destination == Source1)) begin
            rd1 = Write_Data;
        end
        if (wr_accept && (Destination == Source2)) begin
            rd2 = Write_Data;
        end
        if (sweeping && (idx_q == Source1)) begin
            rd1 = '0;
        end
        if (sweeping && (idx_q == Source2)) begin
            rd2 = '0;
        end
`endif
        if ((ZERO_REG != 0) && (Source1 == '0)) begin
            rd1 = '0;
        end
        if ((ZERO_REG != 0) && (Source2 == '0)) begin
            rd2 = '0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            out1_q <= '0;
            out2_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            out1_q <= rd1;
            out2_q <= rd2;
        end
    end

    assign Busy     = sweeping;
    assign Output_1 = out1_q;
    assign Output_2 = out2_q;

endmodule

// File: tb/tb_register_bank_sweep.sv
// Scoreboard bench for register_bank_sweep: two instances (ZERO_REG 0 and 1) share stimulus and
// are checked against an array-based reference model.
module tb_register_bank_sweep;
    localparam int DEPTH = 16;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        we = 1'b0;
    logic        cs = 1'b0;
    logic [3:0]  dst = '0;
    logic [3:0]  s1 = '0;
    logic [3:0]  s2 = '0;
    logic [31:0] wd = '0;
    logic        busy_a, busy_b;
    logic [31:0] o1a, o2a, o1b, o2b;

    always #5 Clock = ~Clock;

    register_bank_sweep #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0)) dut_a (
        .Clock(Clock), .Reset(Reset), .Write_Enable(we), .Destination(dst), .Write_Data(wd),
        .Source1(s1), .Source2(s2), .Clear_Start(cs), .Busy(busy_a),
        .Output_1(o1a), .Output_2(o2a)
    );

    register_bank_sweep #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut_b (
        .Clock(Clock), .Reset(Reset), .Write_Enable(we), .Destination(dst), .Write_Data(wd),
        .Source1(s1), .Source2(s2), .Clear_Start(cs), .Busy(busy_b),
        .Output_1(o1b), .Output_2(o2b)
    );

    typedef struct packed {
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] b1;
        logic [31:0] b2;
        logic        busy;
    } exp_t;

    // Reference model: mem[z] is the bank seen by the ZERO_REG=z instance; sweep_pos is the
    // entry the sweep clears on the next edge, or -1 when idle.
    logic [31:0] mem [2][DEPTH];
    int          sweep_pos;
    exp_t        expq[$];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[z][i] = '0;
            end
        end
        sweep_pos = -1;
    endtask

    // Apply inputs for the coming edge and queue the outputs expected after it.
    task automatic drive_cycle(input logic w, input logic [3:0] d, input logic [31:0] data,
                               input logic [3:0] a1, input logic [3:0] a2, input logic c);
        exp_t        e;
        logic [31:0] r [2][2];
        logic        acc;
        logic [3:0]  s;
        we = w; dst = d; wd = data; s1 = a1; s2 = a2; cs = c;
        for (int z = 0; z < 2; z++) begin
            acc = w && (sweep_pos < 0) && !(z == 1 && d == 4'd0);
            for (int p = 0; p < 2; p++) begin
                s = (p == 0) ? a1 : a2;
                r[z][p] = mem[z][s];
`ifdef REGFILE_BYPASS_EN
                if (acc && d == s) r[z][p] = data;
                if (sweep_pos >= 0 && s == 4'(sweep_pos)) r[z][p] = '0;
`endif
                if (z == 1 && s == 4'd0) r[z][p] = '0;
            end
            if (acc) mem[z][d] = data;
        end
        if (sweep_pos >= 0) begin
            for (int z = 0; z < 2; z++) mem[z][sweep_pos] = '0;
            sweep_pos++;
            if (sweep_pos == DEPTH) sweep_pos = -1;
        end else if (c) begin
            sweep_pos = 0;
        end
        e.a1 = r[0][0]; e.a2 = r[0][1]; e.b1 = r[1][0]; e.b2 = r[1][1];
        e.busy = (sweep_pos >= 0);
        expq.push_back(e);
    endtask

    task automatic step(input logic w, input logic [3:0] d, input logic [31:0] data,
                        input logic [3:0] a1, input logic [3:0] a2, input logic c);
        @(negedge Clock);
        drive_cycle(w, d, data, a1, a2, c);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, holds it over one edge and
    // releases it on the following negedge; the caller drives that cycle.
    task automatic do_reset();
        exp_t e;
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("reset_busy_a", {31'b0, busy_a}, 32'd0);
        check("reset_busy_b", {31'b0, busy_b}, 32'd0);
        check("reset_out1_a", o1a, 32'd0);
        check("reset_out2_a", o2a, 32'd0);
        check("reset_out1_b", o1b, 32'd0);
        check("reset_out2_b", o2b, 32'd0);
        model_clear();
        we = 1'b0; cs = 1'b0;
        e = '0;
        expq.push_back(e);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    always @(posedge Clock) begin : monitor
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("out1_z0", o1a, e.a1);
            check("out2_z0", o2a, e.a2);
            check("out1_z1", o1b, e.b1);
            check("out2_z1", o2b, e.b2);
            check("busy_z0", {31'b0, busy_a}, {31'b0, e.busy});
            check("busy_z1", {31'b0, busy_b}, {31'b0, e.busy});
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cnt;
        model_clear();
        do_reset();
        drive_cycle(1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        for (int a = 0; a < DEPTH; a++) step(1'b0, 4'd0, 32'd0, 4'(a), 4'(15 - a), 1'b0);

        step(1'b1, 4'd1, 32'd8, 4'd0, 4'd0, 1'b0);
        step(1'b1, 4'd2, 32'd16, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 4'd1, 4'd2, 1'b0);
        step(1'b0, 4'd0, 32'd0, 4'd2, 4'd1, 1'b0);

        step(1'b1, 4'd3, 32'd5, 4'd0, 4'd0, 1'b0);
        step(1'b1, 4'd3, 32'hDEAD_BEEF, 4'd3, 4'd3, 1'b0);
        step(1'b0, 4'd0, 32'd0, 4'd3, 4'd3, 1'b0);

        for (int k = 0; k < DEPTH; k++) step(1'b1, 4'(k), 32'(k + 1), 4'(k), 4'(15 - k), 1'b0);
        step(1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(i == 3, 4'd5, 32'd7, 4'($urandom), 4'($urandom), (i == 8));
            if (busy_a) cnt++;
        end
        check("busy_cycles", 32'(cnt), 32'd16);
        for (int a = 0; a < DEPTH; a++) step(1'b0, 4'd0, 32'd0, 4'(a), 4'(a), 1'b0);

        // Write and clear request in the same idle cycle: write lands, then is swept.
        step(1'b1, 4'd9, 32'h99, 4'd9, 4'd0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 32'd0, 4'd9, 4'($urandom), 1'b0);

        for (int k = 0; k < DEPTH; k++) step(1'b1, 4'(k), 32'(k + 100), 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 32'd0, 4'd14, 4'd15, 1'b0);
        do_reset();
        drive_cycle(1'b1, 4'd4, 32'hABCD, 4'd4, 4'd14, 1'b0);
        for (int a = 0; a < DEPTH; a++) step(1'b0, 4'd0, 32'd0, 4'(a), 4'd4, 1'b0);

        step(1'b1, 4'd0, 32'h1234, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        step(1'b1, 4'd15, 32'h5555, 4'd15, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 4'd15, 4'd0, 1'b0);

        for (int i = 0; i < 500; i++) begin
            step(1'($urandom), 4'($urandom), $urandom, 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 39) == 0));
        end

        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
        @(posedge Clock);
        #2;
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
